// File: rtl/dcache_sram_nway.sv
// N-way set-associative tag/data store with age-based LRU, valid/dirty tracking and victim select.
// Optional invalidate-all sequencer is built when DCACHE_SRAM_FLUSH_EN is defined.
module dcache_sram_nway #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 25,
  parameter int LINE_W = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     write_i,
  input  logic [$clog2(SETS)-1:0]  index_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic [LINE_W-1:0]        data_i,
  input  logic                     dirty_i,
  output logic                     hit_o,
  output logic [$clog2(WAYS)-1:0]  way_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic [LINE_W-1:0]        data_o,
  output logic                     valid_o,
  output logic                     dirty_o,
  input  logic                     flush_i,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic [TAG_W-1:0]  tag_mem_r  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem_r [SETS][WAYS];
  logic [WAYS-1:0]   valid_r    [SETS];
  logic [WAYS-1:0]   dirty_r    [SETS];
  logic [WAY_W-1:0]  age_r      [SETS][WAYS];

  logic             busy_s;
  logic             active_s;
  logic             hit_s;
  logic             any_inv_s;
  logic             match_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [WAY_W-1:0] inv_way_s;
  logic [WAY_W-1:0] lru_way_s;
  logic [WAY_W-1:0] sel_way_s;
  logic [WAY_W-1:0] sel_age_s;
  logic             sel_valid_s;
  logic             do_write_s;
  logic             do_touch_s;

`ifdef DCACHE_SRAM_FLUSH_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;
  state_t           state_r;
  logic [IDX_W-1:0] flush_cnt_r;
  logic             busy_r;

  assign busy_s = busy_r;
`else
  logic unused_flush_s;

  assign busy_s         = 1'b0;
  assign unused_flush_s = flush_i;
`endif

  assign active_s   = enable_i & ~busy_s;
  assign do_write_s = active_s & write_i;
  assign do_touch_s = active_s & (hit_s | write_i);
  assign busy_o     = busy_s;

  // Tag match and victim search; descending scan leaves the lowest-index candidate selected.
  always_comb begin
    hit_s     = 1'b0;
    any_inv_s = 1'b0;
    match_s   = 1'b0;
    hit_way_s = '0;
    inv_way_s = '0;
    lru_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s   = valid_r[index_i][w] && (tag_mem_r[index_i][w] == tag_i);
      hit_s     = hit_s | match_s;
      hit_way_s = match_s ? WAY_W'(w) : hit_way_s;
      any_inv_s = any_inv_s | ~valid_r[index_i][w];
      inv_way_s = valid_r[index_i][w] ? inv_way_s : WAY_W'(w);
      lru_way_s = (age_r[index_i][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : lru_way_s;
    end
    sel_way_s   = hit_s ? hit_way_s : (any_inv_s ? inv_way_s : lru_way_s);
    sel_valid_s = valid_r[index_i][sel_way_s];
    sel_age_s   = age_r[index_i][sel_way_s];
  end

  // Drive lookup outputs for the selected way; an invalid way never exposes stale array contents.
  always_comb begin
    if (active_s) begin
      hit_o   = hit_s;
      way_o   = sel_way_s;
      valid_o = sel_valid_s;
      dirty_o = sel_valid_s & dirty_r[index_i][sel_way_s];
      tag_o   = sel_valid_s ? tag_mem_r[index_i][sel_way_s] : '0;
      data_o  = sel_valid_s ? data_mem_r[index_i][sel_way_s] : '0;
    end else begin
      hit_o   = 1'b0;
      way_o   = '0;
      valid_o = 1'b0;
      dirty_o = 1'b0;
      tag_o   = '0;
      data_o  = '0;
    end
  end

  // Tag/data storage is not reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk_i) begin
    if (do_write_s) begin
      data_mem_r[index_i][sel_way_s] <= data_i;
      if (!hit_s) begin
        tag_mem_r[index_i][sel_way_s] <= tag_i;
      end
    end
  end

  // Valid/dirty/age bookkeeping plus the optional invalidate-all sequencer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_r[s][w] <= WAY_W'(w);
        end
      end
`ifdef DCACHE_SRAM_FLUSH_EN
      state_r     <= ST_IDLE;
      flush_cnt_r <= '0;
      busy_r      <= 1'b0;
`endif
    end else begin
      if (do_write_s) begin
        valid_r[index_i][sel_way_s] <= 1'b1;
        dirty_r[index_i][sel_way_s] <= dirty_i;
      end
      // Accessed way becomes youngest; only ways younger than it age, keeping a permutation.
      if (do_touch_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way_s) begin
            age_r[index_i][w] <= '0;
          end else if (age_r[index_i][w] < sel_age_s) begin
            age_r[index_i][w] <= age_r[index_i][w] + WAY_W'(1'b1);
          end
        end
      end
`ifdef DCACHE_SRAM_FLUSH_EN
      case (state_r)
        ST_IDLE: begin
          if (flush_i) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= '0;
            busy_r      <= 1'b1;
          end
        end
        ST_FLUSH: begin
          valid_r[flush_cnt_r] <= '0;
          dirty_r[flush_cnt_r] <= '0;
          for (int w = 0; w < WAYS; w++) begin
            age_r[flush_cnt_r][w] <= WAY_W'(w);
          end
          flush_cnt_r <= flush_cnt_r + IDX_W'(1'b1);
          if (flush_cnt_r == IDX_W'(SETS - 1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed scoreboard bench for dcache_sram_nway: a 2-way and a 4-way instance.
module tb_dcache_sram_nway;

  localparam logic [255:0] Z   = 256'h0;
  localparam logic [255:0] DA5 = {32{8'hA5}};
  localparam logic [255:0] D1  = {8{32'h1111_0001}};
  localparam logic [255:0] D2  = {8{32'h2222_0002}};
  localparam logic [255:0] D3  = {8{32'h3333_0003}};
  localparam logic [255:0] D4  = {8{32'h4444_0004}};
  localparam logic [255:0] D5  = {8{32'h5555_0005}};
  localparam logic [255:0] D6  = {8{32'h6666_0006}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         en2, wr2, dirty2, flush2;
  logic [3:0]   idx2;
  logic [24:0]  tag2;
  logic [255:0] data2;
  logic         hit2, valid2, dirtyo2, busy2;
  logic [0:0]   way2;
  logic [24:0]  tago2;
  logic [255:0] datao2;

  logic         en4, wr4, dirty4, flush4;
  logic [3:0]   idx4;
  logic [24:0]  tag4;
  logic [255:0] data4;
  logic         hit4, valid4, dirtyo4, busy4;
  logic [1:0]   way4;
  logic [24:0]  tago4;
  logic [255:0] datao4;

  dcache_sram_nway #(.SETS(16), .WAYS(2), .TAG_W(25), .LINE_W(256)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en2), .write_i(wr2), .index_i(idx2),
    .tag_i(tag2), .data_i(data2), .dirty_i(dirty2), .hit_o(hit2), .way_o(way2),
    .tag_o(tago2), .data_o(datao2), .valid_o(valid2), .dirty_o(dirtyo2),
    .flush_i(flush2), .busy_o(busy2)
  );

  dcache_sram_nway #(.SETS(16), .WAYS(4), .TAG_W(25), .LINE_W(256)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en4), .write_i(wr4), .index_i(idx4),
    .tag_i(tag4), .data_i(data4), .dirty_i(dirty4), .hit_o(hit4), .way_o(way4),
    .tag_o(tago4), .data_o(datao4), .valid_o(valid4), .dirty_o(dirtyo4),
    .flush_i(flush4), .busy_o(busy4)
  );

  typedef struct {
    string        name;
    logic         hit;
    logic [1:0]   way;
    logic [24:0]  tag;
    logic [255:0] data;
    logic         valid;
    logic         dirty;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic cmp1(input string nm, input string fld, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h", nm, fld, obs, exp);
    end
  endtask

  task automatic check_obs(input logic h, input logic [1:0] w, input logic [24:0] t,
                           input logic [255:0] d, input logic v, input logic dt, input logic b);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      cmp1(e.name, "hit",   256'(h),  256'(e.hit));
      cmp1(e.name, "way",   256'(w),  256'(e.way));
      cmp1(e.name, "tag",   256'(t),  256'(e.tag));
      cmp1(e.name, "data",  d,        e.data);
      cmp1(e.name, "valid", 256'(v),  256'(e.valid));
      cmp1(e.name, "dirty", 256'(dt), 256'(e.dirty));
      cmp1(e.name, "busy",  256'(b),  256'(e.busy));
    end
  endtask

  task automatic chk2();
    check_obs(hit2, {1'b0, way2}, tago2, datao2, valid2, dirtyo2, busy2);
  endtask

  task automatic chk4();
    check_obs(hit4, way4, tago4, datao4, valid4, dirtyo4, busy4);
  endtask

  task automatic push_zero(input string nm, input logic b);
    exp_q.push_back('{nm, 1'b0, 2'd0, 25'h0, Z, 1'b0, 1'b0, b});
  endtask

  task automatic op2(input string nm, input logic wr, input logic [3:0] idx, input logic [24:0] tg,
                     input logic [255:0] d, input logic dty, input logic eh, input logic [1:0] ew,
                     input logic [24:0] et, input logic [255:0] ed, input logic ev, input logic edt);
    @(posedge clk); #1;
    en2 = 1'b1; wr2 = wr; idx2 = idx; tag2 = tg; data2 = d; dirty2 = dty;
    exp_q.push_back('{nm, eh, ew, et, ed, ev, edt, 1'b0});
    @(negedge clk);
    chk2();
  endtask

  task automatic op4(input string nm, input logic wr, input logic [3:0] idx, input logic [24:0] tg,
                     input logic [255:0] d, input logic dty, input logic eh, input logic [1:0] ew,
                     input logic [24:0] et, input logic [255:0] ed, input logic ev, input logic edt);
    @(posedge clk); #1;
    en4 = 1'b1; wr4 = wr; idx4 = idx; tag4 = tg; data4 = d; dirty4 = dty;
    exp_q.push_back('{nm, eh, ew, et, ed, ev, edt, 1'b0});
    @(negedge clk);
    chk4();
  endtask

  task automatic idle();
    @(posedge clk); #1;
    en2 = 1'b0; wr2 = 1'b0; en4 = 1'b0; wr4 = 1'b0; flush2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en2 = 1'b0; wr2 = 1'b0; dirty2 = 1'b0; flush2 = 1'b0; idx2 = 4'd0; tag2 = 25'h0; data2 = Z;
    en4 = 1'b0; wr4 = 1'b0; dirty4 = 1'b0; flush4 = 1'b0; idx4 = 4'd0; tag4 = 25'h0; data4 = Z;
    #2;
    push_zero("reset2", 1'b0); chk2();
    push_zero("reset4", 1'b0); chk4();
    @(negedge clk);
    rst_n = 1'b1;

    // 2-way: basic fill, LRU replacement and dirty victim.
    op2("miss_after_reset", 1'b0, 4'd3, 25'h1ABC, Z,   1'b0, 1'b0, 2'd0, 25'h0,     Z,   1'b0, 1'b0);
    op2("write_cycle_old",  1'b1, 4'd3, 25'h1ABC, DA5, 1'b0, 1'b0, 2'd0, 25'h0,     Z,   1'b0, 1'b0);
    op2("hit_a5",           1'b0, 4'd3, 25'h1ABC, Z,   1'b0, 1'b1, 2'd0, 25'h1ABC,  DA5, 1'b1, 1'b0);
    @(posedge clk); #1;
    en2 = 1'b0;
    push_zero("disabled", 1'b0);
    @(negedge clk); chk2();
    op2("fill_w0",          1'b1, 4'd5, 25'h10,   D1,  1'b0, 1'b0, 2'd0, 25'h0,     Z,   1'b0, 1'b0);
    op2("fill_w1",          1'b1, 4'd5, 25'h20,   D2,  1'b0, 1'b0, 2'd1, 25'h0,     Z,   1'b0, 1'b0);
    op2("hit_10",           1'b0, 4'd5, 25'h10,   Z,   1'b0, 1'b1, 2'd0, 25'h10,    D1,  1'b1, 1'b0);
    op2("miss_30",          1'b0, 4'd5, 25'h30,   Z,   1'b0, 1'b0, 2'd1, 25'h20,    D2,  1'b1, 1'b0);
    op2("write_30",         1'b1, 4'd5, 25'h30,   D3,  1'b0, 1'b0, 2'd1, 25'h20,    D2,  1'b1, 1'b0);
    op2("hit_30",           1'b0, 4'd5, 25'h30,   Z,   1'b0, 1'b1, 2'd1, 25'h30,    D3,  1'b1, 1'b0);
    op2("miss_20",          1'b0, 4'd5, 25'h20,   Z,   1'b0, 1'b0, 2'd0, 25'h10,    D1,  1'b1, 1'b0);
    op2("whit_dirty_10",    1'b1, 4'd5, 25'h10,   D4,  1'b1, 1'b1, 2'd0, 25'h10,    D1,  1'b1, 1'b0);
    op2("hit_dirty_10",     1'b0, 4'd5, 25'h10,   Z,   1'b0, 1'b1, 2'd0, 25'h10,    D4,  1'b1, 1'b1);
    op2("write_40",         1'b1, 4'd5, 25'h40,   D5,  1'b0, 1'b0, 2'd1, 25'h30,    D3,  1'b1, 1'b0);
    op2("victim_dirty",     1'b0, 4'd5, 25'h50,   Z,   1'b0, 1'b0, 2'd0, 25'h10,    D4,  1'b1, 1'b1);
    op2("write_50",         1'b1, 4'd5, 25'h50,   D6,  1'b0, 1'b0, 2'd0, 25'h10,    D4,  1'b1, 1'b1);
    op2("hit_50",           1'b0, 4'd5, 25'h50,   Z,   1'b0, 1'b1, 2'd0, 25'h50,    D6,  1'b1, 1'b0);
    op2("hit_40",           1'b0, 4'd5, 25'h40,   Z,   1'b0, 1'b1, 2'd1, 25'h40,    D5,  1'b1, 1'b0);
    op2("other_set",        1'b0, 4'd3, 25'h1ABC, Z,   1'b0, 1'b1, 2'd0, 25'h1ABC,  DA5, 1'b1, 1'b0);
    op2("write_set15",      1'b1, 4'd15, 25'h1FFFFFF, D1, 1'b1, 1'b0, 2'd0, 25'h0,  Z,   1'b0, 1'b0);
    op2("hit_set15",        1'b0, 4'd15, 25'h1FFFFFF, Z,  1'b0, 1'b1, 2'd0, 25'h1FFFFFF, D1, 1'b1, 1'b1);
    idle();

    // 4-way: fills go to lowest invalid way, then age order decides the victim.
    op4("fill4_w0",     1'b1, 4'd2, 25'h100, D1, 1'b0, 1'b0, 2'd0, 25'h0,   Z,  1'b0, 1'b0);
    op4("fill4_w1",     1'b1, 4'd2, 25'h101, D2, 1'b0, 1'b0, 2'd1, 25'h0,   Z,  1'b0, 1'b0);
    op4("fill4_w2",     1'b1, 4'd2, 25'h102, D3, 1'b0, 1'b0, 2'd2, 25'h0,   Z,  1'b0, 1'b0);
    op4("fill4_w3",     1'b1, 4'd2, 25'h103, D4, 1'b0, 1'b0, 2'd3, 25'h0,   Z,  1'b0, 1'b0);
    op4("hit4_w1",      1'b0, 4'd2, 25'h101, Z,  1'b0, 1'b1, 2'd1, 25'h101, D2, 1'b1, 1'b0);
    op4("lru4_victim0", 1'b0, 4'd2, 25'h1FF, Z,  1'b0, 1'b0, 2'd0, 25'h100, D1, 1'b1, 1'b0);
    op4("hit4_w2",      1'b0, 4'd2, 25'h102, Z,  1'b0, 1'b1, 2'd2, 25'h102, D3, 1'b1, 1'b0);
    op4("hit4_w0",      1'b0, 4'd2, 25'h100, Z,  1'b0, 1'b1, 2'd0, 25'h100, D1, 1'b1, 1'b0);
    op4("hit4_w3",      1'b0, 4'd2, 25'h103, Z,  1'b0, 1'b1, 2'd3, 25'h103, D4, 1'b1, 1'b0);
    op4("hit4_w1b",     1'b0, 4'd2, 25'h101, Z,  1'b0, 1'b1, 2'd1, 25'h101, D2, 1'b1, 1'b0);
    op4("lru4_victim2", 1'b0, 4'd2, 25'h1FF, Z,  1'b0, 1'b0, 2'd2, 25'h102, D3, 1'b1, 1'b0);
    op4("write4_evict", 1'b1, 4'd2, 25'h104, D5, 1'b1, 1'b0, 2'd2, 25'h102, D3, 1'b1, 1'b0);
    op4("hit4_new",     1'b0, 4'd2, 25'h104, Z,  1'b0, 1'b1, 2'd2, 25'h104, D5, 1'b1, 1'b1);
    op4("lru4_victim0b",1'b0, 4'd2, 25'h1FF, Z,  1'b0, 1'b0, 2'd0, 25'h100, D1, 1'b1, 1'b0);
    idle();

`ifdef DCACHE_SRAM_FLUSH_EN
    // Flush: busy for exactly 16 cycles, writes attempted meanwhile are dropped.
    @(posedge clk); #1;
    en2 = 1'b0; flush2 = 1'b1;
    @(posedge clk); #1;
    flush2 = 1'b0; en2 = 1'b1; wr2 = 1'b1; idx2 = 4'd7; tag2 = 25'h77; data2 = D6; dirty2 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      push_zero($sformatf("busy_%0d", k), 1'b1);
      chk2();
      @(posedge clk); #1;
    end
    en2 = 1'b0; wr2 = 1'b0;
    @(negedge clk);
    push_zero("busy_done", 1'b0);
    chk2();
    op2("flushed_7",  1'b0, 4'd7,  25'h77,      Z, 1'b0, 1'b0, 2'd0, 25'h0, Z, 1'b0, 1'b0);
    op2("flushed_3",  1'b0, 4'd3,  25'h1ABC,    Z, 1'b0, 1'b0, 2'd0, 25'h0, Z, 1'b0, 1'b0);
    op2("flushed_5",  1'b0, 4'd5,  25'h50,      Z, 1'b0, 1'b0, 2'd0, 25'h0, Z, 1'b0, 1'b0);
    op2("flushed_15", 1'b0, 4'd15, 25'h1FFFFFF, Z, 1'b0, 1'b0, 2'd0, 25'h0, Z, 1'b0, 1'b0);
    idle();

    // Reset in the middle of a flush drops busy at once.
    @(posedge clk); #1;
    flush2 = 1'b1;
    @(posedge clk); #1;
    flush2 = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_zero("rst_mid_flush", 1'b0);
    chk2();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_zero("after_rst_flush", 1'b0);
    chk2();
`else
    // Without the sequencer, flush_i has no effect and contents survive.
    @(posedge clk); #1;
    en2 = 1'b0; flush2 = 1'b1;
    @(posedge clk); #1;
    flush2 = 1'b0;
    @(negedge clk);
    push_zero("no_busy", 1'b0);
    chk2();
    op2("no_flush_hit", 1'b0, 4'd3, 25'h1ABC, Z, 1'b0, 1'b1, 2'd0, 25'h1ABC, DA5, 1'b1, 1'b0);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
